// File: rtl/pwr_seq_pkg.sv
// Shared definitions for the rail power sequencer: state encodings,
// fault source codes, default timing constants and the registered
// output bundle.
package pwr_seq_pkg;

    // Default timing at 32.768 kHz
    localparam int TIMEOUT_CYC_DEF = 3277;  // ~100 ms PG wait
    localparam int STEP_DLY_DEF    = 33;    // ~1 ms per step
    localparam int RST_DLY_DEF     = 328;   // ~10 ms CPU reset hold
    localparam int CNT_W_DEF       = 12;

    // FSM state encodings (also exported on o_state for debug)
    localparam logic [3:0] ST_OFF      = 4'd0;
    localparam logic [3:0] ST_UP_ATX   = 4'd1;
    localparam logic [3:0] ST_UP_CORE  = 4'd2;
    localparam logic [3:0] ST_UP_VTT   = 4'd3;
    localparam logic [3:0] ST_UP_DLI   = 4'd4;
    localparam logic [3:0] ST_RST_HOLD = 4'd5;
    localparam logic [3:0] ST_RUN      = 4'd6;
    localparam logic [3:0] ST_PD_RST   = 4'd7;
    localparam logic [3:0] ST_PD_DLI   = 4'd8;
    localparam logic [3:0] ST_PD_VTT   = 4'd9;
    localparam logic [3:0] ST_PD_CORE  = 4'd10;
    localparam logic [3:0] ST_PD_ATX   = 4'd11;
    localparam logic [3:0] ST_FAULT    = 4'd12;

    // Failing-rail codes reported on o_fault_src
    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_ATX  = 3'd1;
    localparam logic [2:0] SRC_CORE = 3'd2;
    localparam logic [2:0] SRC_VTT  = 3'd3;
    localparam logic [2:0] SRC_DLI  = 3'd4;

    // Registered output bundle
    typedef struct packed {
        logic       ps_on_n;
        logic       core08_en;
        logic       vtt_en;
        logic       dli_vdd18_en;
        logic       cpu_rst_n;
        logic       fault;
        logic [2:0] fault_src;
    } pwr_out_t;

    // Safe state: ATX off, every rail off, CPU held in reset, no fault
    localparam pwr_out_t PWR_OUT_RST = '{
        ps_on_n:      1'b1,
        core08_en:    1'b0,
        vtt_en:       1'b0,
        dli_vdd18_en: 1'b0,
        cpu_rst_n:    1'b0,
        fault:        1'b0,
        fault_src:    3'd0
    };

    // Lowest-numbered rail whose PG is low; pg[0]=ATX .. pg[3]=DLI
    function automatic logic [2:0] first_fail_src(input logic [3:0] pg);
        logic [2:0] src;
        if (!pg[0]) begin
            src = SRC_ATX;
        end else if (!pg[1]) begin
            src = SRC_CORE;
        end else if (!pg[2]) begin
            src = SRC_VTT;
        end else if (!pg[3]) begin
            src = SRC_DLI;
        end else begin
            src = SRC_NONE;
        end
        return src;
    endfunction

endpackage

// File: rtl/pwr_seq_cnt.sv
// Step counter for the power sequencer: synchronous clear, count enable,
// saturation at all-ones, and two >= threshold compares.
// The compares look at the value the counter takes at the coming edge,
// i.e. the number of cycles spent in the current state including this
// one, so a threshold of N makes a state last exactly N cycles.
module pwr_seq_cnt
    import pwr_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk_32k,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_thr_a,
    input  logic [CNT_W-1:0] i_thr_b,
    output logic             o_ge_a,
    output logic             o_ge_b
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             ge_a_s;
    logic             ge_b_s;

    // Saturating increment of the running count
    always_comb begin
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = CNT_MAX;
        end else begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end
    end

    // Threshold compares on the elapsed-cycle count
    always_comb begin
        ge_a_s = (cnt_inc_s >= i_thr_a);
        ge_b_s = (cnt_inc_s >= i_thr_b);
    end

    // Count register: reset/clear to zero, otherwise count when enabled
    always_ff @(posedge i_clk_32k) begin
        if (i_rst) begin
            cnt_r <= CNT_ZERO;
        end else if (i_clr) begin
            cnt_r <= CNT_ZERO;
        end else if (i_en) begin
            cnt_r <= cnt_inc_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_ge_a = ge_a_s;
    assign o_ge_b = ge_b_s;

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Board power sequencer: brings up ATX, CORE08, VTT and DLI_VDD18 in
// order, releases CPU reset, and powers down in reverse order. A rail
// that misses its PG window latches a fault and drops every rail at once.
// Optional feature: define PWR_SEQ_PGLOSS_MON_EN to also fault on any PG
// loss while in RST_HOLD or RUN.
// All outputs are registered and decoded from the next state so they
// move on the same edge as the state register.
module pwr_seq_ctrl
    import pwr_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int STEP_DLY    = STEP_DLY_DEF,
    parameter int RST_DLY     = RST_DLY_DEF,
    // 2**CNT_W must exceed max(TIMEOUT_CYC, RST_DLY)
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       i_clk_32k,
    input  logic       i_rst,
    input  logic       i_pwr_on_req,
    input  logic       i_pwr_off_req,
    input  logic       i_atx_pg,
    input  logic       i_core08_pg,
    input  logic       i_vtt_pg,
    input  logic       i_dli_vdd18_pg,
    output logic       o_ps_on_n,
    output logic       o_core08_en,
    output logic       o_vtt_en,
    output logic       o_dli_vdd18_en,
    output logic       o_cpu_rst_n,
    output logic       o_fault,
    output logic [2:0] o_fault_src,
    output logic [3:0] o_state
);

    localparam logic [CNT_W-1:0] STEP_THR    = CNT_W'(STEP_DLY);
    localparam logic [CNT_W-1:0] RST_THR     = CNT_W'(RST_DLY);
    localparam logic [CNT_W-1:0] TIMEOUT_THR = CNT_W'(TIMEOUT_CYC);

    logic [3:0]       state_r;
    logic [3:0]       state_nxt_s;
    pwr_out_t         out_r;
    pwr_out_t         out_nxt_s;
    logic [2:0]       entry_src_s;

    logic             rail_pg_s;
    logic [2:0]       rail_src_s;
    logic [3:0]       up_next_s;
    logic [3:0]       pd_next_s;

    logic             cnt_clr_s;
    logic [CNT_W-1:0] thr_a_s;
    logic             ge_a_s;
    logic             ge_b_s;

`ifdef PWR_SEQ_PGLOSS_MON_EN
    logic [3:0]       pg_vec_s;
    logic             pg_loss_s;
    logic [2:0]       loss_src_s;

    // Any rail PG low, and the lowest-numbered rail that is low
    always_comb begin
        pg_vec_s   = {i_dli_vdd18_pg, i_vtt_pg, i_core08_pg, i_atx_pg};
        pg_loss_s  = ~(&pg_vec_s);
        loss_src_s = first_fail_src(pg_vec_s);
    end
`endif

    // Per-UP-state view: which PG is awaited, its fault code, its successor
    always_comb begin
        case (state_r)
            ST_UP_ATX: begin
                rail_pg_s  = i_atx_pg;
                rail_src_s = SRC_ATX;
                up_next_s  = ST_UP_CORE;
            end
            ST_UP_CORE: begin
                rail_pg_s  = i_core08_pg;
                rail_src_s = SRC_CORE;
                up_next_s  = ST_UP_VTT;
            end
            ST_UP_VTT: begin
                rail_pg_s  = i_vtt_pg;
                rail_src_s = SRC_VTT;
                up_next_s  = ST_UP_DLI;
            end
            ST_UP_DLI: begin
                rail_pg_s  = i_dli_vdd18_pg;
                rail_src_s = SRC_DLI;
                up_next_s  = ST_RST_HOLD;
            end
            default: begin
                rail_pg_s  = 1'b1;
                rail_src_s = SRC_NONE;
                up_next_s  = ST_OFF;
            end
        endcase
    end

    // Successor of each power-down step
    always_comb begin
        case (state_r)
            ST_PD_RST:  pd_next_s = ST_PD_DLI;
            ST_PD_DLI:  pd_next_s = ST_PD_VTT;
            ST_PD_VTT:  pd_next_s = ST_PD_CORE;
            ST_PD_CORE: pd_next_s = ST_PD_ATX;
            ST_PD_ATX:  pd_next_s = ST_OFF;
            default:    pd_next_s = ST_OFF;
        endcase
    end

    // Step threshold: RST_HOLD waits RST_DLY, every other step STEP_DLY
    always_comb begin
        if (state_r == ST_RST_HOLD) begin
            thr_a_s = RST_THR;
        end else begin
            thr_a_s = STEP_THR;
        end
    end

    // Next-state logic; fault beats off request, off request beats advance
    always_comb begin
        state_nxt_s = state_r;
        entry_src_s = SRC_NONE;
        case (state_r)
            ST_OFF: begin
                if (i_pwr_on_req && !i_pwr_off_req) begin
                    state_nxt_s = ST_UP_ATX;
                end else begin
                    state_nxt_s = ST_OFF;
                end
            end
            ST_UP_ATX, ST_UP_CORE, ST_UP_VTT, ST_UP_DLI: begin
                if (!rail_pg_s && ge_b_s) begin
                    state_nxt_s = ST_FAULT;
                    entry_src_s = rail_src_s;
                end else if (i_pwr_off_req) begin
                    state_nxt_s = ST_PD_RST;
                end else if (rail_pg_s && ge_a_s) begin
                    state_nxt_s = up_next_s;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RST_HOLD, ST_RUN: begin
`ifdef PWR_SEQ_PGLOSS_MON_EN
                if (pg_loss_s) begin
                    state_nxt_s = ST_FAULT;
                    entry_src_s = loss_src_s;
                end else
`endif
                if (i_pwr_off_req) begin
                    state_nxt_s = ST_PD_RST;
                end else if ((state_r == ST_RST_HOLD) && ge_a_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_PD_RST, ST_PD_DLI, ST_PD_VTT, ST_PD_CORE, ST_PD_ATX: begin
                if (ge_a_s) begin
                    state_nxt_s = pd_next_s;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_FAULT: begin
                if (i_pwr_off_req) begin
                    state_nxt_s = ST_OFF;
                end else begin
                    state_nxt_s = ST_FAULT;
                end
            end
            default: begin
                state_nxt_s = ST_OFF;
            end
        endcase
    end

    // Output decode from the next state; PD steps only ever clear rails
    always_comb begin
        out_nxt_s = PWR_OUT_RST;
        case (state_nxt_s)
            ST_OFF: begin
                out_nxt_s = PWR_OUT_RST;
            end
            ST_UP_ATX: begin
                out_nxt_s.ps_on_n = 1'b0;
            end
            ST_UP_CORE: begin
                out_nxt_s.ps_on_n   = 1'b0;
                out_nxt_s.core08_en = 1'b1;
            end
            ST_UP_VTT: begin
                out_nxt_s.ps_on_n   = 1'b0;
                out_nxt_s.core08_en = 1'b1;
                out_nxt_s.vtt_en    = 1'b1;
            end
            ST_UP_DLI, ST_RST_HOLD: begin
                out_nxt_s.ps_on_n      = 1'b0;
                out_nxt_s.core08_en    = 1'b1;
                out_nxt_s.vtt_en       = 1'b1;
                out_nxt_s.dli_vdd18_en = 1'b1;
            end
            ST_RUN: begin
                out_nxt_s.ps_on_n      = 1'b0;
                out_nxt_s.core08_en    = 1'b1;
                out_nxt_s.vtt_en       = 1'b1;
                out_nxt_s.dli_vdd18_en = 1'b1;
                out_nxt_s.cpu_rst_n    = 1'b1;
            end
            ST_PD_RST: begin
                out_nxt_s.ps_on_n      = out_r.ps_on_n;
                out_nxt_s.core08_en    = out_r.core08_en;
                out_nxt_s.vtt_en       = out_r.vtt_en;
                out_nxt_s.dli_vdd18_en = out_r.dli_vdd18_en;
            end
            ST_PD_DLI: begin
                out_nxt_s.ps_on_n   = out_r.ps_on_n;
                out_nxt_s.core08_en = out_r.core08_en;
                out_nxt_s.vtt_en    = out_r.vtt_en;
            end
            ST_PD_VTT: begin
                out_nxt_s.ps_on_n   = out_r.ps_on_n;
                out_nxt_s.core08_en = out_r.core08_en;
            end
            ST_PD_CORE: begin
                out_nxt_s.ps_on_n = out_r.ps_on_n;
            end
            ST_PD_ATX: begin
                out_nxt_s = PWR_OUT_RST;
            end
            ST_FAULT: begin
                out_nxt_s.fault     = 1'b1;
                out_nxt_s.fault_src = (state_r == ST_FAULT) ? out_r.fault_src : entry_src_s;
            end
            default: begin
                out_nxt_s = PWR_OUT_RST;
            end
        endcase
    end

    // Counter restarts on every state change
    always_comb begin
        cnt_clr_s = (state_nxt_s != state_r);
    end

    pwr_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clk_32k (i_clk_32k),
        .i_rst     (i_rst),
        .i_clr     (cnt_clr_s),
        .i_en      (1'b1),
        .i_thr_a   (thr_a_s),
        .i_thr_b   (TIMEOUT_THR),
        .o_ge_a    (ge_a_s),
        .o_ge_b    (ge_b_s)
    );

    // State and output registers
    always_ff @(posedge i_clk_32k) begin
        if (i_rst) begin
            state_r <= ST_OFF;
            out_r   <= PWR_OUT_RST;
        end else begin
            state_r <= state_nxt_s;
            out_r   <= out_nxt_s;
        end
    end

    assign o_ps_on_n      = out_r.ps_on_n;
    assign o_core08_en    = out_r.core08_en;
    assign o_vtt_en       = out_r.vtt_en;
    assign o_dli_vdd18_en = out_r.dli_vdd18_en;
    assign o_cpu_rst_n    = out_r.cpu_rst_n;
    assign o_fault        = out_r.fault;
    assign o_fault_src    = out_r.fault_src;
    assign o_state        = state_r;

endmodule
